// File: rtl/quota_stream_sequencer.sv
// rtl/quota_stream_sequencer.sv - multi-lane quota-based unipolar stochastic bitstream sequencer
//
// Purpose: accepts one vector of LANES signed QUANT-bit operands, converts each to a
// quota (number of ones) and plays out BITSTREAM beats of one bit per lane.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  operand vector handshake; in_data lane i is [i*QUANT +: QUANT]
//   mode            sampled on accept: 0 = thermometer, 1 = spread (bit-reversed compare)
//   bs_valid/ready  bitstream beat handshake; bs_bits carries one bit per lane
//   bs_first/last   beat 0 / beat BITSTREAM-1 markers
//   busy            a frame is being played out
module quota_stream_sequencer #(
    parameter int BITSTREAM = 64,
    parameter int QUANT     = 8,
    parameter int LANES     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*QUANT-1:0] in_data,
    input  logic                   mode,
    output logic                   bs_valid,
    input  logic                   bs_ready,
    output logic [LANES-1:0]       bs_bits,
    output logic                   bs_first,
    output logic                   bs_last,
    output logic                   busy
);
    localparam int T     = $clog2(BITSTREAM);
    localparam int D     = QUANT - T;
    localparam int QW    = QUANT + 1;
    localparam int QB    = T + 1;
    localparam int RND_I = (D > 0) ? (1 << (D - 1)) : 0;
    localparam logic [T-1:0] CNT_LAST = T'(BITSTREAM - 1);

    if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_bad_bitstream
        $error("quota_stream_sequencer: BITSTREAM must be a power of two");
    end
    if (QUANT < T) begin : g_bad_quant
        $error("quota_stream_sequencer: QUANT must be >= clog2(BITSTREAM)");
    end

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t         state, next_state;
    logic [T-1:0]   cnt;
    logic [T-1:0]   cnt_rev;
    logic [T:0]     cmp_idx;
    logic           mode_r;
    logic [T:0]     q_r  [LANES];
    logic [T:0]     q_in [LANES];
    logic           accept;
    logic           beat;

    // Quota conversion. Adding 2^(QUANT-1) to a two's complement value is the same
    // as flipping its sign bit and reading it unsigned; the extra bit holds the
    // rounding carry so max positive reaches BITSTREAM instead of wrapping.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [QUANT-1:0] d;
        logic [QUANT:0]   biased;
        logic [QUANT:0]   shifted;

        assign d       = in_data[i*QUANT +: QUANT];
        assign biased  = {1'b0, ~d[QUANT-1], d[QUANT-2:0]} + QW'(RND_I);
        assign shifted = biased >> D;
        assign q_in[i] = (shifted > QW'(BITSTREAM)) ? QB'(BITSTREAM) : shifted[T:0];

        // T+1-bit compare so a quota of BITSTREAM yields a one on every beat.
        assign bs_bits[i] = (state == ST_STREAM) && (cmp_idx < q_r[i]);
    end

    // Spread mode compares against the bit-reversed beat index, which spaces the
    // ones evenly while still producing exactly q ones over the frame.
    always_comb begin
        cnt_rev = '0;
        for (int b = 0; b < T; b++) begin
            cnt_rev[b] = cnt[T-1-b];
        end
    end

    assign cmp_idx = mode_r ? {1'b0, cnt_rev} : {1'b0, cnt};

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = ST_STREAM;
            end
            ST_STREAM: begin
                // Last beat being consumed: a new vector may load with no bubble.
                if (bs_ready && cnt == CNT_LAST) begin
                    in_ready = 1'b1;
                    if (!in_valid) next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign beat     = (state == ST_STREAM) && bs_ready;
    assign bs_valid = (state == ST_STREAM);
    assign busy     = (state == ST_STREAM);
    assign bs_first = (state == ST_STREAM) && (cnt == '0);
    assign bs_last  = (state == ST_STREAM) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            mode_r <= 1'b0;
            for (int i = 0; i < LANES; i++) q_r[i] <= '0;
        end else if (accept) begin
            cnt    <= '0;
            mode_r <= mode;
            for (int i = 0; i < LANES; i++) q_r[i] <= q_in[i];
        end else if (beat) begin
            // Wraps to zero on the final beat, leaving cnt cleared in IDLE.
            cnt <= cnt + T'(1);
        end
    end

endmodule

// File: tb/tb_quota_stream_sequencer.sv
// tb/tb_quota_stream_sequencer.sv - directed self-checking bench for quota_stream_sequencer
module tb_quota_stream_sequencer;
    localparam int BITSTREAM = 64;
    localparam int QUANT     = 8;
    localparam int LANES     = 4;

    // lanes {-128,0,-126,127} and {0,2,-127,1}, lane 0 in the low byte
    localparam logic [31:0] VEC_A = 32'h7F82_0080;
    localparam logic [31:0] VEC_B = 32'h0181_0200;
    // quotas packed 7 bits per lane, lane 0 low: A={0,32,1,64}, B={32,33,0,32}
    localparam logic [27:0] Q_A = {7'd64, 7'd1, 7'd32, 7'd0};
    localparam logic [27:0] Q_B = {7'd32, 7'd0, 7'd33, 7'd32};

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*QUANT-1:0] in_data = '0;
    logic                   mode = 1'b0;
    logic                   bs_valid;
    logic                   bs_ready = 1'b0;
    logic [LANES-1:0]       bs_bits;
    logic                   bs_first;
    logic                   bs_last;
    logic                   busy;

    int n_cmp = 0;
    int n_bad = 0;

    quota_stream_sequencer #(
        .BITSTREAM(BITSTREAM),
        .QUANT    (QUANT),
        .LANES    (LANES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .mode    (mode),
        .bs_valid(bs_valid),
        .bs_ready(bs_ready),
        .bs_bits (bs_bits),
        .bs_first(bs_first),
        .bs_last (bs_last),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_bits(input logic [27:0] q, input int beat, input logic m);
        logic [5:0] b;
        logic [5:0] r;
        int         idx;
        b = beat[5:0];
        for (int k = 0; k < 6; k++) r[k] = b[5-k];
        idx = m ? int'(r) : beat;
        for (int l = 0; l < 4; l++) exp_bits[l] = (idx < int'(q[l*7 +: 7]));
    endfunction

    // Called at a negedge with the sequencer idle; returns at the negedge of beat 0.
    task automatic start_frame(input string name, input logic [31:0] d, input logic m);
        in_data  = d;
        mode     = m;
        in_valid = 1'b1;
        bs_ready = 1'b1;
        #1;
        check({name, "/in_ready_idle"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic play(input string name, input logic [27:0] q, input logic m, input bit stall,
                        input logic nv, input logic [31:0] nd, input logic nm);
        int beats = 0;
        int cyc   = 0;
        int lasts = 0;
        int ones [4];
        for (int l = 0; l < 4; l++) ones[l] = 0;
        while (beats < BITSTREAM && cyc < 1000) begin
            in_valid = nv;
            in_data  = nd;
            mode     = nm;
            bs_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check({name, "/bs_valid"}, bs_valid, 1);
            check({name, "/busy"}, busy, 1);
            check({name, "/bs_bits"}, bs_bits, exp_bits(q, beats, m));
            check({name, "/bs_first"}, bs_first, beats == 0);
            check({name, "/bs_last"}, bs_last, beats == BITSTREAM - 1);
            check({name, "/in_ready"}, in_ready, (beats == BITSTREAM - 1) && bs_ready);
            if (bs_ready) begin
                for (int l = 0; l < 4; l++) ones[l] += int'(bs_bits[l]);
                if (bs_last) lasts++;
                beats++;
            end
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        check({name, "/beats"}, beats, BITSTREAM);
        check({name, "/last_count"}, lasts, 1);
        for (int l = 0; l < 4; l++) check({name, "/ones"}, ones[l], int'(q[l*7 +: 7]));
        #1;
        if (nv) begin
            check({name, "/next_valid"}, bs_valid, 1);
            check({name, "/next_first"}, bs_first, 1);
        end else begin
            check({name, "/end_valid"}, bs_valid, 0);
            check({name, "/end_busy"}, busy, 0);
            check({name, "/end_in_ready"}, in_ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset/bs_valid", bs_valid, 0);
        check("reset/busy", busy, 0);
        check("reset/in_ready", in_ready, 1);
        check("reset/bs_bits", bs_bits, 0);
        check("reset/bs_first", bs_first, 0);
        check("reset/bs_last", bs_last, 0);
        @(negedge clk);

        start_frame("thermo", VEC_A, 1'b0);
        play("thermo", Q_A, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        start_frame("spread", VEC_B, 1'b1);
        play("spread", Q_B, 1'b1, 1'b0, 1'b0, '0, 1'b0);

        start_frame("stall", VEC_A, 1'b1);
        play("stall", Q_A, 1'b1, 1'b1, 1'b0, '0, 1'b0);

        start_frame("b2b_a", VEC_A, 1'b0);
        play("b2b_a", Q_A, 1'b0, 1'b0, 1'b1, VEC_B, 1'b1);
        play("b2b_b", Q_B, 1'b1, 1'b0, 1'b0, '0, 1'b0);

        start_frame("midrst", VEC_A, 1'b0);
        in_valid = 1'b0;
        bs_ready = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("midrst/beat20_bits", bs_bits, exp_bits(Q_A, 20, 1'b0));
        check("midrst/beat20_first", bs_first, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst/bs_valid", bs_valid, 0);
        check("midrst/busy", busy, 0);
        check("midrst/in_ready", in_ready, 1);
        check("midrst/bs_bits", bs_bits, 0);
        check("midrst/bs_last", bs_last, 0);
        @(negedge clk);
        start_frame("after_rst", VEC_B, 1'b1);
        play("after_rst", Q_B, 1'b1, 1'b0, 1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/quota_stream_sequencer.md
Name: quota_stream_sequencer

Overview:
- Multi-lane controller that turns one vector of signed QUANT-bit operands into unipolar stochastic bitstreams of length BITSTREAM.
- Each accepted vector is converted to per-lane quotas, registered, then played out one bit per lane per cycle for BITSTREAM beats.
- Sits between the quantised activation/weight buffer and the stochastic MAC array; output backpressure stalls the stream.

Parameters:
- BITSTREAM, 64, stream length in beats; must be 2^n, elaboration error otherwise.
- QUANT, 8, operand width; must satisfy QUANT >= $clog2(BITSTREAM), elaboration error otherwise.
- LANES, 4, number of parallel operands/streams per frame.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand vector valid.
- in_ready  output  1  sequencer can accept a vector this cycle.
- in_data  input  LANES*QUANT  signed operands; lane i is [i*QUANT +: QUANT].
- mode  input  1  sampled on accept: 0 = thermometer, 1 = spread (bit-reversed compare).
- bs_valid  output  1  bs_bits valid.
- bs_ready  input  1  consumer accepts the current beat.
- bs_bits  output  LANES  one stochastic bit per lane.
- bs_first  output  1  high on beat 0 of a frame.
- bs_last  output  1  high on beat BITSTREAM-1 of a frame.
- busy  output  1  frame in progress, i.e. state STREAM.

Behaviour:
- Derived widths: T = $clog2(BITSTREAM), D = QUANT-T. Each quota register is T+1 bits.
- Quota per lane: q = (data + 2^(QUANT-1) + (D>0 ? 2^(D-1) : 0)) >> D.
  - Computed unsigned in QUANT+1 bits.
  - Clamped to BITSTREAM, so data = max positive gives an all-ones stream. No wrap to 0.
- FSM states are IDLE and STREAM.
  - IDLE: in_ready=1 and bs_valid=0. On in_valid, latch the quotas and mode, clear beat counter cnt (T bits), and go to STREAM.
  - STREAM: bs_valid=1. On bs_valid&bs_ready, cnt increments.
  - When the accepted beat has cnt == BITSTREAM-1, return to IDLE. Exception: if in_valid is also high, reload immediately (back-to-back case below).
- Back-to-back frames:
  - in_ready = IDLE | (STREAM & cnt==BITSTREAM-1 & bs_ready). This is a combinational path from bs_ready.
  - Accepting on the last beat reloads the quotas and sets cnt=0, with no bubble beat.
- Latency: vector accepted in cycle N gives beat 0 with bs_valid=1 in cycle N+1.
- Bit generation, lane i, from registered state only:
  - Thermometer mode: bs_bits[i] = (cnt < q_i).
  - Spread mode: bs_bits[i] = (bitrev_T(cnt) < q_i).
  - Compare is in T+1 bits, so q_i = BITSTREAM gives 1 on every beat.
- Ones count: exactly q_i ones per frame in both modes.
- Flags: bs_first = STREAM & cnt==0. bs_last = STREAM & cnt==BITSTREAM-1.
- Stall: with bs_ready=0, bs_bits, bs_first, bs_last and cnt hold. in_data is ignored outside accept cycles.
- Reset values (including reset mid-frame): state=IDLE, cnt=0, quotas=0, mode=0, bs_valid=0, bs_bits=0, bs_first=0, bs_last=0, busy=0. After reset release, in_ready=1 on the next cycle. The partially played frame is dropped, not resumed.
- All outputs are glitch-free registered or decoded from registered state, except in_ready as noted above.

Test Plan:
- Config BITSTREAM=64, QUANT=8, LANES=4, mode=0, in_data lanes {-128,0,-126,127}.
  - Quotas {0,32,1,64}.
  - Lane0 all 0; lane1 1 for beats 0-31; lane2 1 only on beat 0; lane3 all 1.
  - bs_first on beat 0, bs_last on beat 63, in_ready=0 during beats 0-62.
- Same config, mode=1, lanes {0,2,-127,1}.
  - Quotas {32,33,0,32}.
  - Lane0 1 on even beats only; lane1 even beats plus beat 1; lane2 all 0.
  - Each lane's total ones equals its quota.
- Backpressure: toggle bs_ready pseudo-randomly over a frame.
  - Outputs hold while stalled.
  - Exactly 64 accepted beats; bs_last seen once; ones count unchanged.
- Back-to-back: in_valid held high with a new vector, bs_ready=1.
  - in_ready pulses on beat 63; next cycle is beat 0 of the new frame with new quotas.
  - No beat with bs_valid=0 between frames.
- Reset mid-frame: assert rst at beat 20 for 1 cycle.
  - Next cycle: bs_valid=0, busy=0, in_ready=1.
  - A new vector then starts cleanly at beat 0.
- Elaboration: BITSTREAM=48, or QUANT=4 with BITSTREAM=64 -> elaboration error reported.
